// File: rtl/button_conditioner.sv
// Four-button front end: two-flop synchroniser and debounce per button, registered
// rising-edge pulses, and a fixed-priority direction command (U > D > L > R).

module button_channel #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  typedef enum logic {STABLE, CHANGING} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;
  state_t           state;

  // Plain flop-to-flop synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // The phase follows directly from the synced input against the accepted level.
  always_comb begin
    state     = (s2 != level) ? CHANGING : STABLE;
    cnt_nxt   = '0;
    level_nxt = level;
    case (state)
      STABLE:   cnt_nxt = '0;
      CHANGING: begin
        if (cnt == LAST) begin
          level_nxt = s2;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default:  cnt_nxt = '0;
    endcase
  end

  assign rise = level_nxt & ~level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_U_RAW,
  input  logic       BTN_D_RAW,
  input  logic       BTN_L_RAW,
  input  logic       BTN_R_RAW,
  output logic       BTN_U,
  output logic       BTN_D,
  output logic       BTN_L,
  output logic       BTN_R,
  output logic [3:0] PRESS,
  output logic [1:0] DIR,
  output logic       DIR_VALID
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] raw, level, rise;
  logic [1:0]           dir_nxt;

  assign raw = {BTN_R_RAW, BTN_L_RAW, BTN_D_RAW, BTN_U_RAW};

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch [NUM_LANES-1:0] (
    .clk  (CLK),
    .rst_n(RESET),
    .raw  (raw),
    .level(level),
    .rise (rise)
  );

  assign {BTN_R, BTN_L, BTN_D, BTN_U} = level;

  // Lower-priority simultaneous presses are dropped; the direction code is the lane index.
  always_comb begin
    dir_nxt = DIR;
    if      (rise[0]) dir_nxt = 2'd0;
    else if (rise[1]) dir_nxt = 2'd1;
    else if (rise[2]) dir_nxt = 2'd2;
    else if (rise[3]) dir_nxt = 2'd3;
  end

  // Registered off the channels' next-state so PRESS lands in the first cycle the level is high.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PRESS     <= '0;
      DIR       <= 2'd0;
      DIR_VALID <= 1'b0;
    end else begin
      PRESS     <= rise;
      DIR       <= dir_nxt;
      DIR_VALID <= |rise;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed table-driven bench for button_conditioner with a short debounce window.

module tb_button_conditioner;
  localparam int DC = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BTN_U_RAW, BTN_D_RAW, BTN_L_RAW, BTN_R_RAW;
  logic       BTN_U, BTN_D, BTN_L, BTN_R;
  logic [3:0] PRESS;
  logic [1:0] DIR;
  logic       DIR_VALID;

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTN_U_RAW(BTN_U_RAW), .BTN_D_RAW(BTN_D_RAW), .BTN_L_RAW(BTN_L_RAW), .BTN_R_RAW(BTN_R_RAW),
    .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_L(BTN_L), .BTN_R(BTN_R),
    .PRESS(PRESS), .DIR(DIR), .DIR_VALID(DIR_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] raw;    // {R,L,D,U}
    logic [3:0] btn;    // {R,L,D,U}
    logic [3:0] press;
    logic [1:0] dir;
    logic       dv;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  wire [3:0] btn = {BTN_R, BTN_L, BTN_D, BTN_U};

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic rep(input int n, input logic [3:0] raw, input logic [3:0] b, input logic [3:0] p,
                     input logic [1:0] d, input logic dv);
    vec_t v;
    v.raw = raw; v.btn = b; v.press = p; v.dir = d; v.dv = dv;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] raw);
    {BTN_R_RAW, BTN_L_RAW, BTN_D_RAW, BTN_U_RAW} = raw;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] b, input logic [3:0] p,
                           input logic [1:0] d, input logic dv);
    check({tag, ".btn"},   idx, {4'h0, btn},   {4'h0, b});
    check({tag, ".press"}, idx, {4'h0, PRESS}, {4'h0, p});
    check({tag, ".dir"},   idx, {6'h0, DIR},   {6'h0, d});
    check({tag, ".dv"},    idx, {7'h0, DIR_VALID}, {7'h0, dv});
  endtask

  initial begin
    int n;
    // U press, held: level and pulse on the 6th edge
    rep(5, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0);
    rep(1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1);
    rep(2, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
    // U release: level falls 6 edges later, no pulse
    rep(5, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0);
    rep(2, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // L glitch for 3 cycles: counter reaches DC-1 but never times out
    rep(3, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0);
    rep(8, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // D and R together: both pulse, D wins
    rep(5, 4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b0);
    rep(1, 4'b1010, 4'b1010, 4'b1010, 2'd1, 1'b1);
    rep(2, 4'b1010, 4'b1010, 4'b0000, 2'd1, 1'b0);
    rep(5, 4'b0000, 4'b1010, 4'b0000, 2'd1, 1'b0);
    rep(2, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    // U press while L bounces once: channels stay independent
    rep(1, 4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0);
    rep(1, 4'b0101, 4'b0000, 4'b0000, 2'd1, 1'b0);
    rep(3, 4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0);
    rep(1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1);
    rep(1, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
    rep(5, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0);
    rep(2, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // U, then L 20 cycles later: exactly two strobes, DIR 00 -> 10
    rep(5,  4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0);
    rep(1,  4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1);
    rep(14, 4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
    rep(5,  4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0);
    rep(1,  4'b0101, 4'b0101, 4'b0100, 2'd2, 1'b1);
    rep(2,  4'b0101, 4'b0101, 4'b0000, 2'd2, 1'b0);

    // Reset state
    RESET = 1'b0;
    drive(4'b0000);
    #2;
    check_all("rst_async", 0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check_all("rst_clk", 0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].raw);
      @(posedge CLK);
      #1;
      check_all("vec", i, vecs[i].btn, vecs[i].press, vecs[i].dir, vecs[i].dv);
    end

    // R held, reset lands mid-debounce; U/L are still releasing
    drive(4'b1000);
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    check("mid.btn", 0, {4'h0, btn}, 8'h05);
    #2;
    RESET = 1'b0;
    #1;
    check_all("mid_rst", 0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK);
      #1;
      if (BTN_R) begin
        n = k;
        break;
      end
    end
    check("rst_r.latency", 0, 8'(n), 8'(DC + 2));
    check_all("rst_r.rise", 0, 4'b1000, 4'b1000, 2'd3, 1'b1);
    @(posedge CLK);
    #1;
    check_all("rst_r.after", 0, 4'b1000, 4'b0000, 2'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
